// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesting clients and the round-robin arbiter.
// The end-of-tenure strobe is named grant_release because `release` is a reserved word.
interface rr_grant_arbiter_if #(
    parameter int N = 8
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic             grant_release;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output grant_release,
        input  grant,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  grant_release,
        output grant,
        output grant_idx,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter: rotating-mask find-first-one winner selection
// plus a grant-hold FSM with release, withdrawal and hold-budget handover.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] arb_ptr;
    logic [N-1:0]     mask;
    logic [N-1:0]     hi;
    logic [IDX_W-1:0] winner_idx;
    logic [N-1:0]     winner_oh;
    logic             hold_lim;
    logic             withdrew;
    logic             end_t;

    function automatic logic [IDX_W-1:0] ffo_idx(input logic [N-1:0] v);
        ffo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) ffo_idx = IDX_W'(i);
        end
    endfunction

    assign hold_lim = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD - 1));
    assign withdrew = !bus.req[idx_q];
    assign end_t    = (state_q == GRANT) && (bus.grant_release || withdrew || hold_lim);

    // On handover the outgoing grantee becomes the new pointer in the same cycle
    assign arb_ptr = end_t ? idx_q : ptr_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(arb_ptr));
        end
    end

    assign hi         = bus.req & mask;
    assign winner_idx = (|hi) ? ffo_idx(hi) : ffo_idx(bus.req);

    always_comb begin
        winner_oh             = '0;
        winner_oh[winner_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = winner_oh;
                    idx_d   = winner_idx;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!end_t) begin
                    hold_d = hold_q + CNT_W'(1);
                end else begin
                    ptr_d     = idx_q;
                    timeout_d = hold_lim && !bus.grant_release && !withdrew;
                    hold_d    = '0;
                    if (|bus.req) begin
                        grant_d = winner_oh;
                        idx_d   = winner_idx;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= IDX_W'(N - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=4, MAX_HOLD=4): vector table plus a
// hand-written asynchronous-reset-mid-tenure sequence.
module tb_rr_grant_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_grant_arbiter_if #(.N(N)) bus ();

    rr_grant_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] req;
        logic       rel;
        logic [3:0] grant;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic rel, input logic [3:0] grant,
                       input logic busy, input logic tmo);
        vec_t v;
        v.req   = req;
        v.rel   = rel;
        v.grant = grant;
        v.busy  = busy;
        v.tmo   = tmo;
        vecs.push_back(v);
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] g);
        oh2idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) oh2idx = 2'(i);
        end
    endfunction

    initial begin
        bus.req           = 4'b0000;
        bus.grant_release = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        // req=1010, release every 3rd cycle: 0010,1000,0010,1000
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 4'b1000, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b1000, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b1010, 1'b1, 4'b1000, 1'b1, 1'b0);
        // req=0111: grantee 3 withdraws, then 4-cycle tenures with timeouts
        for (int i = 0; i < 4; i++) add(4'b0111, 1'b0, 4'b0001, 1'b1, 1'b0);
        add(4'b0111, 1'b0, 4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0111, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b0111, 1'b0, 4'b0100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0111, 1'b0, 4'b0100, 1'b1, 1'b0);
        add(4'b0111, 1'b0, 4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0111, 1'b0, 4'b0001, 1'b1, 1'b0);
        add(4'b0111, 1'b0, 4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0111, 1'b0, 4'b0010, 1'b1, 1'b0);
        add(4'b0111, 1'b0, 4'b0100, 1'b1, 1'b1);
        // non-grantee toggles, then grantee 2 withdraws with req[0] up
        add(4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0);
        add(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
        // release coincides with hold limit: handover, no timeout
        for (int i = 0; i < 3; i++) add(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
        add(4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);
        add(4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0);
        // all drop -> idle; release ignored in idle; pointer kept at 1
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        add(4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0);
        // sole requester re-granted; pointer becomes 2
        add(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("reset grant", 32'(bus.grant), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset timeout", 32'(bus.timeout), 32'h0);
        check("reset grant_idx", 32'(bus.grant_idx), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.req           = vecs[i].req;
            bus.grant_release = vecs[i].rel;
            @(posedge clk);
            #1;
            check($sformatf("row%0d grant", i), 32'(bus.grant), 32'(vecs[i].grant));
            check($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            check($sformatf("row%0d timeout", i), 32'(bus.timeout), 32'(vecs[i].tmo));
            if (vecs[i].busy)
                check($sformatf("row%0d grant_idx", i), 32'(bus.grant_idx),
                      32'(oh2idx(vecs[i].grant)));
        end

        // asynchronous reset mid-tenure (grant=0100, pointer=2)
        bus.grant_release = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst grant", 32'(bus.grant), 32'h0);
        check("async rst busy", 32'(bus.busy), 32'h0);
        check("async rst timeout", 32'(bus.timeout), 32'h0);
        bus.req = 4'b1100;
        @(posedge clk);
        #1;
        check("rst held grant", 32'(bus.grant), 32'h0);
        check("rst held busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst grant", 32'(bus.grant), 32'b0100);
        check("post rst busy", 32'(bus.busy), 32'h1);
        check("post rst grant_idx", 32'(bus.grant_idx), 32'h2);
        check("post rst timeout", 32'(bus.timeout), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
